// File: rtl/sprite_palette_bank.sv
// Run-time writable, multi-bank sprite palette: colour index -> 12-bit RGB through a 2-stage
// pipeline, with transparency flag, frame-synchronous bank switch and hit-flash effect.
module sprite_palette_bank #(
    parameter int INDEX_W      = 4,
    parameter int NUM_BANKS    = 4,
    parameter int TRANSP_INDEX = 0,
    parameter bit TRANSP_EN    = 1'b1,
    parameter int FLASH_FRAMES = 8,
    localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [BANK_W-1:0]  bank_req,
    input  logic               pix_valid,
    input  logic [INDEX_W-1:0] pix_index,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [11:0]        wr_data,
    input  logic               flash_en,
    output logic               out_valid,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               transparent,
    output logic [BANK_W-1:0]  active_bank
);

    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int CNT_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    function automatic logic [11:0] reset_entry(input int idx);
        if (idx == 0) return 12'hFF0;
        if (idx == 1) return 12'h000;
        return 12'hDDD;
    endfunction

    logic [11:0]        pal_q [NUM_BANKS][ENTRIES];
    logic [11:0]        pal_d [NUM_BANKS][ENTRIES];
    logic               s1_valid_q;
    logic [INDEX_W-1:0] s1_idx_q;
    logic [BANK_W-1:0]  active_bank_q, active_bank_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic               out_valid_q, out_valid_d;
    logic [11:0]        color_q, color_d;
    logic               transp_q, transp_d;
    logic [11:0]        rd_color;
    logic               rd_transp;

    always_comb begin
        active_bank_d = active_bank_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        pal_d         = pal_q;
        out_valid_d   = s1_valid_q;
        color_d       = color_q;
        transp_d      = transp_q;

        if (frame_start && (int'(bank_req) < NUM_BANKS)) begin
            active_bank_d = bank_req;
        end

        if (!flash_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (frame_start) begin
            if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (wr_en && (int'(wr_bank) < NUM_BANKS)) begin
            pal_d[wr_bank][wr_index] = wr_data;
        end

        // Read uses pre-write contents (old value on collision) and the post-switch bank.
        rd_color  = pal_q[active_bank_d][s1_idx_q];
        rd_transp = TRANSP_EN && (s1_idx_q == INDEX_W'(TRANSP_INDEX));
        if (phase_q && flash_en && !rd_transp) begin
            rd_color = 12'hFFF;
        end

        if (s1_valid_q) begin
            color_d  = rd_color;
            transp_d = rd_transp;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    pal_q[b][i] <= reset_entry(i);
                end
            end
            s1_valid_q    <= 1'b0;
            s1_idx_q      <= '0;
            active_bank_q <= '0;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            color_q       <= '0;
            transp_q      <= 1'b0;
        end else begin
            pal_q         <= pal_d;
            s1_valid_q    <= pix_valid;
            s1_idx_q      <= pix_index;
            active_bank_q <= active_bank_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            out_valid_q   <= out_valid_d;
            color_q       <= color_d;
            transp_q      <= transp_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign red         = color_q[11:8];
    assign green       = color_q[7:4];
    assign blue        = color_q[3:0];
    assign transparent = transp_q;
    assign active_bank = active_bank_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: a frame-level palette model predicts each pixel,
// a monitor compares whatever the DUT presents on out_valid.
module tb_sprite_palette_bank;

    localparam int INDEX_W = 4;
    localparam int NB      = 3;
    localparam int BANK_W  = 2;
    localparam int FF      = 2;
    localparam int ENTRIES = 16;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               frame_start;
    logic [BANK_W-1:0]  bank_req;
    logic               pix_valid;
    logic [INDEX_W-1:0] pix_index;
    logic               wr_en;
    logic [BANK_W-1:0]  wr_bank;
    logic [INDEX_W-1:0] wr_index;
    logic [11:0]        wr_data;
    logic               flash_en;
    logic               out_valid;
    logic [3:0]         red, green, blue;
    logic               transparent;
    logic [BANK_W-1:0]  active_bank;

    sprite_palette_bank #(
        .INDEX_W      (INDEX_W),
        .NUM_BANKS    (NB),
        .TRANSP_INDEX (0),
        .TRANSP_EN    (1'b1),
        .FLASH_FRAMES (FF)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .bank_req    (bank_req),
        .pix_valid   (pix_valid),
        .pix_index   (pix_index),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .flash_en    (flash_en),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .active_bank (active_bank)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: palette contents, bank, flash frame count/phase, pixel awaiting lookup.
    logic [11:0] m_pal [NB][ENTRIES];
    int          m_bank;
    int          m_cnt;
    bit          m_phase;
    bit          m_pend_v;
    int          m_pend_idx;
    logic [12:0] sb[$];
    logic [12:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_pal[b][i] = (i == 0) ? 12'hFF0 : (i == 1) ? 12'h000 : 12'hDDD;
            end
        end
        m_bank   = 0;
        m_cnt    = 0;
        m_phase  = 0;
        m_pend_v = 0;
        m_last   = '0;
        sb.delete();
    endtask

    // Applies one clock edge's worth of behaviour to the model, using the inputs held at that edge.
    task automatic model_step();
        logic [11:0] col;
        bit          tr;
        if (frame_start && int'(bank_req) < NB) m_bank = int'(bank_req);
        if (m_pend_v) begin
            col = m_pal[m_bank][m_pend_idx];
            tr  = (m_pend_idx == 0);
            if (m_phase && flash_en && !tr) col = 12'hFFF;
            sb.push_back({tr, col});
        end
        if (wr_en && int'(wr_bank) < NB) m_pal[wr_bank][wr_index] = wr_data;
        if (!flash_en) begin
            m_cnt   = 0;
            m_phase = 0;
        end else if (frame_start) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == FF) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end
        end
        m_pend_v   = pix_valid;
        m_pend_idx = int'(pix_index);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        check("active_bank", {30'b0, active_bank}, m_bank);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input int idx);
        pix_valid = 1'b1;
        pix_index = INDEX_W'(idx);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic frame(input int bank);
        frame_start = 1'b1;
        bank_req    = BANK_W'(bank);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wr(input int bank, input int idx, input logic [11:0] data);
        wr_en    = 1'b1;
        wr_bank  = BANK_W'(bank);
        wr_index = INDEX_W'(idx);
        wr_data  = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, {31'b0, out_valid}, 0);
        check({name, "_rgb"}, {20'b0, red, green, blue}, 0);
        check({name, "_transp"}, {31'b0, transparent}, 0);
        check({name, "_bank"}, {30'b0, active_bank}, 0);
    endtask

    task automatic read_all_banks();
        for (int b = 0; b < NB; b++) begin
            frame(b);
            idle(2);
            for (int i = 0; i < ENTRIES; i++) pix(i);
            idle(3);
        end
    endtask

    // Monitor: pops one expectation per valid output; checks hold behaviour otherwise.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got 1, expected 0 at %0t", $time);
                end else begin
                    m_last = sb.pop_front();
                    check("pixel_rgb", {20'b0, red, green, blue}, {20'b0, m_last[11:0]});
                    check("pixel_transp", {31'b0, transparent}, {31'b0, m_last[12]});
                end
            end else begin
                check("hold_rgb", {20'b0, red, green, blue}, {20'b0, m_last[11:0]});
                check("hold_transp", {31'b0, transparent}, {31'b0, m_last[12]});
            end
        end
    end

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        bank_req    = '0;
        pix_valid   = 1'b0;
        pix_index   = '0;
        wr_en       = 1'b0;
        wr_bank     = '0;
        wr_index    = '0;
        wr_data     = '0;
        flash_en    = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Reset defaults and transparency of index 0.
        pix(0); pix(1); pix(5);
        idle(3);

        // Write a non-active bank, switch to it, confirm bank 0 untouched.
        wr(2, 3, 12'h1A5);
        frame(2);
        idle(2);
        pix(3);
        idle(3);
        frame(0);
        idle(2);
        pix(3);
        idle(3);

        // Write lands on the same edge as the S2 read of that entry.
        pix(7);
        wr(0, 7, 12'h0F0);
        pix(7);
        idle(3);

        // Flash with two frames per half-period.
        flash_en = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            frame(0);
            idle(2);
            pix(0); pix(1); pix(7);
            idle(3);
        end
        flash_en = 1'b0;
        tick();
        pix(1);
        idle(3);

        // Out-of-range bank request and write.
        frame(1);
        frame(3);
        wr(3, 4, 12'h123);
        idle(2);
        read_all_banks();

        // Randomised traffic with blanking-period bank switches and flash toggles.
        for (int f = 0; f < 10; f++) begin
            flash_en = ($urandom_range(0, 2) != 0);
            tick();
            frame($urandom_range(0, 3));
            idle(2);
            for (int c = 0; c < 30; c++) begin
                pix_valid = ($urandom_range(0, 3) != 0);
                pix_index = INDEX_W'($urandom_range(0, ENTRIES - 1));
                wr_en     = ($urandom_range(0, 2) == 0);
                wr_bank   = BANK_W'($urandom_range(0, 3));
                wr_index  = INDEX_W'($urandom_range(0, ENTRIES - 1));
                wr_data   = 12'($urandom);
                tick();
            end
            pix_valid = 1'b0;
            wr_en     = 1'b0;
            idle(3);
        end
        flash_en = 1'b0;
        tick();

        // Reset asserted with pixels in flight after writes.
        wr(1, 2, 12'hABC);
        pix(2); pix(3);
        pix_valid = 1'b1;
        pix_index = 4'd9;
        Reset_n   = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        pix_valid = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        check_reset_outputs("reset_held");
        Reset_n = 1'b1;
        read_all_banks();

        idle(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
